// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder:
// data width, RV32I load/store width codes and FSM states.
package dmem_responder_pkg;

    localparam int BIN_DIG = 32;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for loads and stores within one 32-bit word,
// plus alignment / funct3 / range error detection.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]         funct3,
    input  logic               we,
    input  logic [1:0]         addr_lo,
    input  logic               addr_ok,
    input  logic [BIN_DIG-1:0] rword,
    input  logic [BIN_DIG-1:0] wdata,
    output logic [3:0]         be,
    output logic [BIN_DIG-1:0] wword,
    output logic [BIN_DIG-1:0] ldata,
    output logic               err
);

    logic [7:0]         byte_v;
    logic [15:0]        half_v;
    logic               misalign;
    logic               bad_f3;
    logic [3:0]         be_raw;
    logic [BIN_DIG-1:0] ld_raw;

    assign byte_v = rword[{addr_lo, 3'b000} +: 8];
    assign half_v = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        misalign = 1'b0;
        bad_f3   = 1'b0;
        be_raw   = 4'b0000;
        wword    = '0;
        ld_raw   = '0;
        unique case (funct3)
            F3_B: begin
                be_raw = 4'b0001 << addr_lo;
                wword  = {4{wdata[7:0]}};
                ld_raw = {{24{byte_v[7]}}, byte_v};
            end
            F3_H: begin
                misalign = addr_lo[0];
                be_raw   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword    = {2{wdata[15:0]}};
                ld_raw   = {{16{half_v[15]}}, half_v};
            end
            F3_W: begin
                misalign = addr_lo != 2'b00;
                be_raw   = 4'b1111;
                wword    = wdata;
                ld_raw   = rword;
            end
            F3_BU: begin
                bad_f3 = we;
                ld_raw = {24'd0, byte_v};
            end
            F3_HU: begin
                misalign = addr_lo[0];
                bad_f3   = we;
                ld_raw   = {16'd0, half_v};
            end
            default: bad_f3 = 1'b1;
        endcase
        err   = !addr_ok || misalign || bad_f3;
        be    = (we && !err) ? be_raw : 4'b0000;
        ldata = (!we && !err) ? ld_raw : '0;
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the CPU load/store interface: one request at a
// time, fixed latency, owns the word-organised data RAM.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [BIN_DIG-1:0] req_addr,
    input  logic [BIN_DIG-1:0] req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [BIN_DIG-1:0] rsp_rdata,
    output logic               rsp_err
);

    localparam int WORDS = 2 ** (ADDR_W - 2);

    dmem_state_t        state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [2:0]         f3_q, f3_d;
    logic [BIN_DIG-1:0] addr_q, addr_d;
    logic [BIN_DIG-1:0] wdata_q, wdata_d;
    logic [BIN_DIG-1:0] rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               commit;

    logic [BIN_DIG-1:0] mem [WORDS];
    logic [BIN_DIG-1:0] rword;
    logic [3:0]         be;
    logic [BIN_DIG-1:0] wword;
    logic [BIN_DIG-1:0] ldata;
    logic               acc_err;
    logic               addr_ok;

    assign addr_ok = addr_q[BIN_DIG-1:ADDR_W] == '0;
    assign rword   = mem[addr_q[ADDR_W-1:2]];

    dmem_lane_align u_align (
        .funct3  (f3_q),
        .we      (we_q),
        .addr_lo (addr_q[1:0]),
        .addr_ok (addr_ok),
        .rword   (rword),
        .wdata   (wdata_q),
        .be      (be),
        .wword   (wword),
        .ldata   (ldata),
        .err     (acc_err)
    );

    assign req_ready = (state_q == DMEM_IDLE) && !RST;
    assign rsp_valid = state_q == DMEM_RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        unique case (state_q)
            DMEM_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = DMEM_WAIT;
                end
            end
            DMEM_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    rdata_d = ldata;
                    err_d   = acc_err;
                    state_d = DMEM_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DMEM_RESP: begin
                if (rsp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = DMEM_IDLE;
                end
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Reset on the commit edge suppresses the write.
    always_ff @(posedge CLK) begin
        if (commit && !RST) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

endmodule
